data_mem_ctrl: RTL
==================

# data_mem_ctrl

Multi-cycle data-memory controller for the MIPS32 pipelined core, sitting in the MEM stage between the EX/MEM pipeline register and the MEM/WB register, in place of the combinational data memory. It accepts one `lw`/`sw` request per instruction, models a fixed number of SRAM wait states through a counter-driven FSM, and asserts `stall` so the rest of the pipeline freezes until the access completes. It also detects misaligned, out-of-range and conflicting requests and records them in a sticky error flag.

## Interface
- `SIZE_DATA`, 32, data word width
- `ADD_SIZE`, 32, byte-address width
- `DEPTH_WORDS`, 256, number of 32-bit words in the array (power of two)
- `LAT`, 2, SRAM wait states, legal range 1..15

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `MemRead`  in  1  load request from EX/MEM M field
- `MemWrite`  in  1  store request from EX/MEM M field
- `address`  in  ADD_SIZE  byte address (EX/MEM ALU result)
- `dato`  in  SIZE_DATA  store data
- `err_clr`  in  1  clears `err`
- `datoLeido`  out  SIZE_DATA  registered load data, to MEM/WB
- `stall`  out  1  freeze PC, IF_ID, ID_EX, EX_MEM; bubble into MEM_WB
- `done`  out  1  one-cycle pulse: access completed this cycle
- `err`  out  1  sticky error flag

## Operation
- FSM states: IDLE, BUSY, DONE.
- Request valid = `MemRead` XOR `MemWrite`, `address[1:0]`==0, word index < `DEPTH_WORDS`.
- IDLE, valid request: latch op/address/data, `cnt` <= LAT-1, go BUSY.
- IDLE, invalid request (misaligned, out of range, or both strobes high): `err` <= 1, no access, no stall, stay IDLE.
- BUSY: `cnt`>0 -> decrement; `cnt`==0 -> perform access at this edge (write array, or load `datoLeido`), go DONE.
- DONE: `stall`=0, `done`=1; go IDLE unconditionally. The held EX/MEM request is not re-issued during DONE.
- `stall` = (IDLE and valid request) or BUSY; combinational from the inputs in IDLE.
- `datoLeido` holds its value until the next completed load; stores leave it unchanged.
- `err` is set by any invalid request and cleared only by `err_clr` or reset; a set event wins over a simultaneous `err_clr`.
- Word index = `address[log2(DEPTH_WORDS)+1:2]`; the upper address bits must be zero, otherwise the request is out of range.
- Reset, including mid-access: state IDLE, `cnt` 0, `datoLeido` 0, `err` 0, `stall` 0, `done` 0. A pending store is dropped. Array contents are not reset.

## Timing
- Request seen in IDLE at cycle 0: `stall` high for cycles 0..LAT, i.e. LAT+1 cycles.
- Access takes effect at the end of cycle LAT.
- `done`=1 and the new `datoLeido` are visible in cycle LAT+1, and MEM_WB captures them at the end of that cycle.
- Back-to-back memory instructions: the next request is seen in IDLE at cycle LAT+2, so the spacing is LAT+2 cycles.
- Non-memory instructions pass with zero stall.

## Structure
- Shared package `mips_pkg`: the FSM state enum (`MEM_IDLE`, `MEM_BUSY`, `MEM_DONE`), the `SIZE_DATA` and `ADD_SIZE` constants, and the alignment-mask constant.
- Sub-module `sram_sp`: single-port synchronous RAM with a write enable and a registered read port, parameterised on `DEPTH_WORDS` and `SIZE_DATA`.
- The FSM, the counter and the error logic stay in `data_mem_ctrl`.

## Test plan
- With LAT=2: `sw` to 0x10 with data 0xDEADBEEF, then `lw` from 0x10 -> `stall` high 3 cycles for each access, `done` pulses in cycle 3 of each, `datoLeido`=0xDEADBEEF after the load.
- `lw` from 0x12 -> `err`=1, `stall` never asserts, `datoLeido` unchanged. Then `err_clr` -> `err`=0.
- `MemRead` and `MemWrite` both high at 0x20 -> `err`=1, no array write (a later `lw` 0x20 returns the prior value).
- `sw` to byte address 0x400 with DEPTH_WORDS=256 -> `err`=1, no stall, no write at 0x000.
- `reset` low in BUSY during `sw` 0x30 = 0x1234 -> next cycle IDLE with `stall`=0; a later `lw` 0x30 returns the old contents.
- Sweep LAT=1 and LAT=15 with back-to-back `lw` -> stall length LAT+1 and request spacing LAT+2 cycles exactly.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Types and constants shared by the MIPS32 memory-stage blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int c_SIZE_DATA = 32;
    localparam int c_ADD_SIZE  = 32;

    // Byte-offset bits that must be zero for a word access
    localparam logic [1:0] c_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/sram_sp.sv
`default_nettype none
// ============================================================================
//  Module      : sram_sp
//  Description : Single-port synchronous RAM, write enable, registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_sp #(
    parameter int DEPTH_WORDS = 256,
    parameter int SIZE_DATA   = 32,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [SIZE_DATA-1:0] wdata,
    output logic [SIZE_DATA-1:0] rdata
);

    logic [SIZE_DATA-1:0] r_mem [DEPTH_WORDS];
    logic [SIZE_DATA-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en && we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Read register only moves on a read, so it holds across stores
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (en && !we) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule : sram_sp
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Multi-cycle MEM-stage data memory controller with stall/err.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
    import mips_pkg::*;
#(
    parameter int SIZE_DATA   = c_SIZE_DATA,
    parameter int ADD_SIZE    = c_ADD_SIZE,
    parameter int DEPTH_WORDS = 256,
    parameter int LAT         = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [ADD_SIZE-1:0]  address,
    input  logic [SIZE_DATA-1:0] dato,
    input  logic                 err_clr,
    output logic [SIZE_DATA-1:0] datoLeido,
    output logic                 stall,
    output logic                 done,
    output logic                 err
);

    localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_CNT_LOAD = 4'(LAT - 1);

    mem_state_t             r_state;
    logic [3:0]             r_cnt;
    logic                   r_we;
    logic [c_IDX_W-1:0]     r_idx;
    logic [SIZE_DATA-1:0]   r_wdata;
    logic                   r_done;
    logic                   r_err;

    logic w_req;
    logic w_aligned;
    logic w_in_range;
    logic w_valid;
    logic w_err_set;
    logic w_access;

    assign w_req      = MemRead | MemWrite;
    assign w_aligned  = (address[1:0] & c_ALIGN_MASK) == 2'b00;
    assign w_in_range = (address >> (c_IDX_W + 2)) == '0;
    assign w_valid    = (MemRead ^ MemWrite) & w_aligned & w_in_range;
    assign w_err_set  = (r_state == MEM_IDLE) & w_req & ~w_valid;

    // Gated by reset so a store caught mid-access never lands in the array
    assign w_access   = (r_state == MEM_BUSY) & (r_cnt == 4'd0) & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= MEM_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            case (r_state)
                MEM_IDLE: begin
                    if (w_valid) begin
                        r_we    <= MemWrite;
                        r_idx   <= address[c_IDX_W+1:2];
                        r_wdata <= dato;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= MEM_BUSY;
                    end
                end
                MEM_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    r_state <= MEM_IDLE;
                end
                default: begin
                    r_state <= MEM_IDLE;
                end
            endcase
        end
    end

    sram_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .SIZE_DATA   (SIZE_DATA)
    ) u_sram (
        .clk   (clk),
        .reset (reset),
        .en    (w_access),
        .we    (r_we),
        .addr  (r_idx),
        .wdata (r_wdata),
        .rdata (datoLeido)
    );

    assign stall = ((r_state == MEM_IDLE) & w_valid) | (r_state == MEM_BUSY);
    assign done  = r_done;
    assign err   = r_err;

endmodule : data_mem_ctrl
`default_nettype wire
